// File: rtl/memory_access.sv
// memory_access: MEM pipeline stage. It issues data-memory loads and stores and returns a write-back bundle; optional feature macro: MEM_ALIGN_CHECK_EN.
// Latency: a non-memory op (or a rejected misaligned access) writes back 1 cycle after acceptance; a memory op writes back 2 cycles after dmem_ack is sampled.
// Backpressure: ex_ready is high only in IDLE, so one operation is in flight at a time. A request that is never acked is abandoned after TIMEOUT ACCESS cycles.
module memory_access #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [4:0]  rDestSelected,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemSigned,
    input  logic        RegWrite,
    input  logic [1:0]  MemSize,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_rDest,
    output logic [31:0] wb_Data,
    output logic        bus_err,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_e      state_q, state_d;

    // Operation captured on acceptance
    logic [31:0] alu_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        signed_q;
    logic        regwrite_q;
    logic [4:0]  rdest_q;

    // Access bookkeeping
    logic [7:0]  cnt_q;
    logic        err_q;
    logic [31:0] rdata_q;

    // Registered output pulses and write-back bundle
    logic        wb_valid_q, wb_valid_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [4:0]  wb_rdest_q, wb_rdest_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        bus_err_q, bus_err_d;

    // Decoded view of the incoming Execute result
    logic        accept;
    logic        is_mem_in;
    logic        mis_in;
    logic        start_mem;
    logic [1:0]  size_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic        timeout_hit;

    // Load extraction from the captured read data
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;

    assign accept      = ex_valid & ex_ready;
    assign is_mem_in   = MemRead | MemWrite;
    assign start_mem   = accept & is_mem_in & ~mis_in;
    // The comparison is made on the incremented count, so the abort happens on the edge where the counter would reach TIMEOUT.
    assign timeout_hit = ((cnt_q + 8'd1) == TO_LIMIT);

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;

    // Half accesses must be 2-byte aligned and word accesses 4-byte aligned.
    assign mis_in = is_mem_in &
                    (((size_in == SZ_HALF) & ALUResult[0]) |
                     ((size_in == SZ_WORD) & (ALUResult[1:0] != 2'b00)));

    // Single-cycle misalign pulse raised when a misaligned access is accepted
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept & mis_in;
        end
    end

    assign misalign = misalign_q;
`else
    // Without the check, half accesses ignore addr[0] and word accesses ignore addr[1:0].
    assign mis_in   = 1'b0;
    assign misalign = 1'b0;
`endif

    // Size normalisation and store lane steering (little-endian) for the incoming op
    always_comb begin
        size_in  = (MemSize == 2'b11) ? SZ_WORD : MemSize;
        be_in    = 4'b1111;
        wdata_in = WriteData;
        if (MemWrite) begin
            case (size_in)
                SZ_BYTE: begin
                    be_in    = 4'b0001 << ALUResult[1:0];
                    wdata_in = {4{WriteData[7:0]}};
                end
                SZ_HALF: begin
                    be_in    = ALUResult[1] ? 4'b1100 : 4'b0011;
                    wdata_in = {2{WriteData[15:0]}};
                end
                default: begin
                    be_in    = 4'b1111;
                    wdata_in = WriteData;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: an ack outranks a timeout that falls on the same edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_mem) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (dmem_ack || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        ex_ready = (state_q == S_IDLE);
        dmem_req = (state_q == S_ACCESS);
        dmem_we  = (state_q == S_ACCESS) & we_q;
    end

    // Capture every input on acceptance so the memory interface stays stable through ACCESS
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            alu_q      <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            lane_q     <= '0;
            signed_q   <= 1'b0;
            regwrite_q <= 1'b0;
            rdest_q    <= '0;
        end else if (accept) begin
            alu_q      <= ALUResult;
            wdata_q    <= wdata_in;
            be_q       <= be_in;
            we_q       <= MemWrite;
            size_q     <= size_in;
            lane_q     <= ALUResult[1:0];
            signed_q   <= MemSigned;
            regwrite_q <= RegWrite;
            rdest_q    <= rDestSelected;
        end
    end

    // Timeout counter, error flag and load-data capture
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (start_mem) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end else if (state_q == S_ACCESS) begin
                if (dmem_ack) begin
                    rdata_q <= dmem_rdata;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                    if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Lane select plus sign/zero extension of the captured load data
    always_comb begin
        case (lane_q)
            2'd0:    load_byte = rdata_q[7:0];
            2'd1:    load_byte = rdata_q[15:8];
            2'd2:    load_byte = rdata_q[23:16];
            default: load_byte = rdata_q[31:24];
        endcase
        load_half = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{signed_q & load_byte[7]}}, load_byte};
            SZ_HALF: load_val = {{16{signed_q & load_half[15]}}, load_half};
            default: load_val = rdata_q;
        endcase
    end

    // Write-back and error pulse next-state: immediate ops in IDLE, memory ops from RESP
    always_comb begin
        wb_valid_d    = 1'b0;
        wb_regwrite_d = 1'b0;
        wb_rdest_d    = wb_rdest_q;
        wb_data_d     = wb_data_q;
        bus_err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && (!is_mem_in || mis_in)) begin
                    wb_valid_d    = 1'b1;
                    wb_rdest_d    = rDestSelected;
                    wb_data_d     = ALUResult;
                    wb_regwrite_d = RegWrite & ~is_mem_in & (rDestSelected != 5'd0);
                end
            end
            S_ACCESS: begin
                bus_err_d = ~dmem_ack & timeout_hit;
            end
            S_RESP: begin
                wb_valid_d    = 1'b1;
                wb_rdest_d    = rdest_q;
                wb_data_d     = (we_q | err_q) ? alu_q : load_val;
                wb_regwrite_d = regwrite_q & ~we_q & ~err_q & (rdest_q != 5'd0);
            end
            default: begin
                wb_valid_d = 1'b0;
            end
        endcase
    end

    // Write-back and error output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rdest_q    <= '0;
            wb_data_q     <= '0;
            bus_err_q     <= 1'b0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_rdest_q    <= wb_rdest_d;
            wb_data_q     <= wb_data_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign dmem_addr   = {alu_q[31:2], 2'b00};
    assign dmem_wdata  = wdata_q;
    assign dmem_be     = be_q;
    assign wb_valid    = wb_valid_q;
    assign wb_RegWrite = wb_regwrite_q;
    assign wb_rDest    = wb_rdest_q;
    assign wb_Data     = wb_data_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed and random transactions on memory_access, checked against a behavioural model.
// Latency: checks sample on the falling edge, half a cycle after each rising edge.
// Backpressure: one transaction at a time; a new op is driven only when the block is back in IDLE.
module tb_memory_access;

    localparam int TO = 15;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [4:0]  rDestSelected;
    logic        MemRead, MemWrite, MemSigned, RegWrite;
    logic [1:0]  MemSize;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_RegWrite;
    logic [4:0]  wb_rDest;
    logic [31:0] wb_Data;
    logic        bus_err, misalign;

    int n_chk  = 0;
    int n_fail = 0;

    memory_access #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ALUResult(ALUResult), .WriteData(WriteData), .rDestSelected(rDestSelected),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSigned(MemSigned), .RegWrite(RegWrite),
        .MemSize(MemSize),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rDest(wb_rDest), .wb_Data(wb_Data),
        .bus_err(bus_err), .misalign(misalign)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %08h expected %08h", tag, field, obs, exp);
        end
    endtask

    // Effective size: 0 byte, 1 half, 2 word (illegal 3 behaves as word)
    function automatic int eff_size(input logic [1:0] sz);
        return (sz == 2'd3) ? 2 : int'(sz);
    endfunction

    function automatic bit exp_mis(input logic [1:0] sz, input logic [31:0] a);
        int s;
        s = eff_size(sz);
        return ALIGN_CHK && ((s == 1 && (a % 2) != 0) || (s == 2 && (a % 4) != 0));
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a, input bit st);
        int s;
        s = eff_size(sz);
        if (!st || s == 2) return 4'hF;
        if (s == 0) return 4'(1 << (a % 4));
        return ((a % 4) >= 2) ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
        int s;
        s = eff_size(sz);
        if (s == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (s == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic [31:0] a,
                                             input logic [31:0] rd, input bit sg);
        logic [31:0] v;
        int s;
        s = eff_size(sz);
        if (s == 0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (sg && v >= 32'd128) v = v - 32'd256;
        end else if (s == 1) begin
            v = (rd >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v - 32'h1_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Drives one op from IDLE (caller sits on a falling edge) and checks it through to the return to IDLE.
    task automatic run_txn(input string tag, input bit rd, input bit wr, input bit sg, input bit rw,
                           input logic [1:0] sz, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] rdst, input logic [31:0] rdata, input int ack_dly);
        bit is_mem, is_st, mis, err;
        int req_cycles;
        is_mem = rd || wr;
        is_st  = wr;
        mis    = is_mem && exp_mis(sz, alu);
        err    = ack_dly >= TO;
        check(tag, "ex_ready_idle", ex_ready, 1);
        ex_valid = 1'b1; ALUResult = alu; WriteData = wd; rDestSelected = rdst;
        MemRead = rd; MemWrite = wr; MemSigned = sg; RegWrite = rw; MemSize = sz;
        dmem_rdata = $urandom;
        @(negedge Clk);
        // Scramble the inputs so anything not registered on acceptance shows up
        ex_valid = 1'b0; ALUResult = $urandom; WriteData = $urandom; rDestSelected = 5'($urandom);
        MemRead = 1'($urandom); MemWrite = 1'($urandom); MemSigned = 1'($urandom);
        RegWrite = 1'($urandom); MemSize = 2'($urandom);
        if (!is_mem || mis) begin
            check(tag, "wb_valid", wb_valid, 1);
            check(tag, "wb_RegWrite", wb_RegWrite, (!is_mem && rw && rdst != 0) ? 1 : 0);
            check(tag, "wb_rDest", wb_rDest, rdst);
            if (!is_mem) check(tag, "wb_Data", wb_Data, alu);
            check(tag, "misalign", misalign, mis ? 1 : 0);
            check(tag, "dmem_req", dmem_req, 0);
        end else begin
            req_cycles = err ? TO : ack_dly + 1;
            for (int k = 0; k < req_cycles; k++) begin
                check(tag, "dmem_req", dmem_req, 1);
                check(tag, "ex_ready_busy", ex_ready, 0);
                if (k == 0 || k == req_cycles - 1) begin
                    check(tag, "dmem_addr", dmem_addr, alu & 32'hFFFF_FFFC);
                    check(tag, "dmem_we", dmem_we, is_st ? 1 : 0);
                    check(tag, "dmem_be", dmem_be, exp_be(sz, alu, is_st));
                    if (is_st) check(tag, "dmem_wdata", dmem_wdata, exp_wdata(sz, wd));
                end
                if (k == ack_dly) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                end
                @(negedge Clk);
                dmem_rdata = $urandom;
            end
            // RESP cycle: any ack here must be ignored
            dmem_ack = 1'($urandom);
            check(tag, "dmem_req_resp", dmem_req, 0);
            check(tag, "bus_err", bus_err, err ? 1 : 0);
            check(tag, "wb_valid_resp", wb_valid, 0);
            @(negedge Clk);
            dmem_ack = 1'b0;
            check(tag, "wb_valid", wb_valid, 1);
            check(tag, "wb_RegWrite", wb_RegWrite, (!is_st && !err && rw && rdst != 0) ? 1 : 0);
            check(tag, "wb_rDest", wb_rDest, rdst);
            if (!is_st && !err) check(tag, "wb_Data", wb_Data, exp_load(sz, alu, rdata, sg));
            check(tag, "bus_err_pulse", bus_err, 0);
        end
        @(negedge Clk);
        check(tag, "wb_valid_pulse", wb_valid, 0);
        check(tag, "misalign_pulse", misalign, 0);
        check(tag, "ex_ready_back", ex_ready, 1);
        check(tag, "dmem_req_idle", dmem_req, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op, dly;
        bit rd, wr;
        Reset_n = 1'b0; ex_valid = 1'b0; ALUResult = '0; WriteData = '0; rDestSelected = '0;
        MemRead = 1'b0; MemWrite = 1'b0; MemSigned = 1'b0; RegWrite = 1'b0; MemSize = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;

        // Reset state
        @(negedge Clk);
        check("reset", "ex_ready", ex_ready, 1);
        check("reset", "dmem_req", dmem_req, 0);
        check("reset", "dmem_we", dmem_we, 0);
        check("reset", "dmem_addr", dmem_addr, 0);
        check("reset", "dmem_be", dmem_be, 0);
        check("reset", "wb_valid", wb_valid, 0);
        check("reset", "wb_Data", wb_Data, 0);
        check("reset", "bus_err", bus_err, 0);
        check("reset", "misalign", misalign, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Directed scenarios
        run_txn("alu_op",    0, 0, 0, 1, 2'd2, 32'h0000_1234, 32'h0,         5'd5,  32'h0,         0);
        run_txn("alu_r0",    0, 0, 0, 1, 2'd2, 32'h0000_5678, 32'h0,         5'd0,  32'h0,         0);
        run_txn("lb_signed", 1, 0, 1, 1, 2'd0, 32'h0000_0103, 32'h0,         5'd9,  32'h80FF_FF7F, 3);
        run_txn("sh_0x202",  0, 1, 0, 1, 2'd1, 32'h0000_0202, 32'h0000_ABCD, 5'd3,  32'h0,         1);
        run_txn("lw_timeout",1, 0, 0, 1, 2'd2, 32'h0000_0400, 32'h0,         5'd7,  32'h1111_2222, 100);
        run_txn("ack_at_lim",1, 0, 0, 1, 2'd2, 32'h0000_0500, 32'h0,         5'd8,  32'hCAFE_F00D, TO - 1);
        run_txn("lhu_hi",    1, 0, 0, 1, 2'd1, 32'h0000_0602, 32'h0,         5'd10, 32'h9876_5432, 0);
        run_txn("sw_rd_wr",  1, 1, 0, 1, 2'd3, 32'h0000_0700, 32'hDEAD_BEEF, 5'd11, 32'h0,         2);
        run_txn("lw_0x302",  1, 0, 0, 1, 2'd2, 32'h0000_0302, 32'h0,         5'd12, 32'h0BAD_C0DE, 0);

        // Reset asserted in the middle of an access
        check("rst_mid", "ex_ready", ex_ready, 1);
        ex_valid = 1'b1; ALUResult = 32'h0000_0800; MemRead = 1'b1; MemWrite = 1'b0;
        MemSize = 2'd2; RegWrite = 1'b1; rDestSelected = 5'd4;
        @(negedge Clk);
        ex_valid = 1'b0;
        @(negedge Clk);
        check("rst_mid", "dmem_req_before", dmem_req, 1);
        Reset_n = 1'b0;
        #1;
        check("rst_mid", "dmem_req_now", dmem_req, 0);
        check("rst_mid", "ex_ready_now", ex_ready, 1);
        dmem_ack = 1'b1;
        @(negedge Clk);
        dmem_ack = 1'b0;
        Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("rst_mid", "wb_valid", wb_valid, 0);
            check("rst_mid", "dmem_req", dmem_req, 0);
            @(negedge Clk);
        end

        // Random transactions against the model
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 3);
            rd = (op == 1) || (op == 3);
            wr = (op == 2) || (op == 3);
            dly = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 4);
            run_txn($sformatf("rnd%0d", i), rd, wr, 1'($urandom), 1'($urandom),
                    2'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom, dly);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
